// File: rtl/key_result_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_result_collector_pkg
//  Description : Shared constants and the collector state type for the RC4
//                key search result collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_result_collector_pkg;

    localparam int C_CORE_COUNT_LOG_2 = 3;
    localparam int C_KEY_W            = 22;
    localparam int C_TIMER_W          = 32;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_SEARCH = 2'd1;
    localparam logic [1:0] C_ST_FOUND  = 2'd2;
    localparam logic [1:0] C_ST_FAILED = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = C_ST_IDLE,
        SEARCH = C_ST_SEARCH,
        FOUND  = C_ST_FOUND,
        FAILED = C_ST_FAILED
    } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/key_result_collector_lowest_set_index.sv
`default_nettype none
// ============================================================================
//  Module      : lowest_set_index
//  Description : Combinational priority encoder returning the index of the
//                lowest set bit of i_vec. o_any flags that any bit is set;
//                o_idx is 0 when none is set.
//  Ports       : i_vec [N]     - request vector
//                o_idx [LOG2N] - index of lowest set bit
//                o_any         - at least one bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_index #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic [N-1:0]     i_vec,
    output logic [LOG2N-1:0] o_idx,
    output logic             o_any
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = LOG2N'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : key_result_collector
//  Description : Collects results from the parallel RC4 brute-force cores.
//                Picks the lowest-index core reporting a match, latches its
//                key, halts all cores, times the search and drives the
//                display word and status LEDs. Reports failure when every
//                core has exhausted its slice without a match.
//  Ports       : clk, reset_n (async, active low)
//                start          - search enable level; rising edge starts
//                core_found/done/key - per-core status and current key
//                stop_all       - halt request to the cores
//                key_valid, key_out, winner_id, search_failed - results
//                elapsed_cycles - saturating count of SEARCH cycles
//                display, ledr  - board display word and status LEDs
//  Revision    : 1.0 - initial release
// ============================================================================
module key_result_collector
    import key_result_collector_pkg::*;
#(
    parameter int CORE_COUNT_LOG_2 = C_CORE_COUNT_LOG_2,
    parameter int CORE_COUNT       = 2 ** CORE_COUNT_LOG_2,
    parameter int KEY_W            = C_KEY_W,
    parameter int TIMER_W          = C_TIMER_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [CORE_COUNT-1:0]       core_found,
    input  logic [CORE_COUNT-1:0]       core_done,
    input  logic [CORE_COUNT*KEY_W-1:0] core_key,
    output logic                        stop_all,
    output logic                        key_valid,
    output logic [KEY_W-1:0]            key_out,
    output logic [CORE_COUNT_LOG_2-1:0] winner_id,
    output logic                        search_failed,
    output logic [TIMER_W-1:0]          elapsed_cycles,
    output logic [KEY_W-1:0]            display,
    output logic [9:0]                  ledr
);

    collector_state_t            r_state, w_state_nxt;
    logic                        r_start_q;
    logic                        r_stop_all, w_stop_all_nxt;
    logic                        r_key_valid, w_key_valid_nxt;
    logic [KEY_W-1:0]            r_key_out, w_key_out_nxt;
    logic [CORE_COUNT_LOG_2-1:0] r_winner_id, w_winner_nxt;
    logic                        r_failed, w_failed_nxt;
    logic [TIMER_W-1:0]          r_elapsed, w_elapsed_nxt;
    logic [KEY_W-1:0]            r_display, w_display_nxt;
    logic [9:0]                  r_ledr, w_ledr_nxt;

    logic                        w_start_rise;
    logic [CORE_COUNT_LOG_2-1:0] w_win_idx;
    logic                        w_any_found;
    logic [KEY_W-1:0]            w_keys [CORE_COUNT];
    logic [KEY_W-1:0]            w_key_or;

    assign w_start_rise = start & ~r_start_q;

    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_key_unpack
        assign w_keys[g] = core_key[g*KEY_W +: KEY_W];
    end

    always_comb begin
        w_key_or = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            w_key_or = w_key_or | w_keys[i];
        end
    end

    lowest_set_index #(
        .N     (CORE_COUNT),
        .LOG2N (CORE_COUNT_LOG_2)
    ) u_winner_sel (
        .i_vec (core_found),
        .o_idx (w_win_idx),
        .o_any (w_any_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // All outputs are computed from next-state values so that they change
    // on the same edge as the state they describe.
    always_comb begin
        w_state_nxt     = r_state;
        w_stop_all_nxt  = 1'b0;
        w_key_valid_nxt = r_key_valid;
        w_key_out_nxt   = r_key_out;
        w_winner_nxt    = r_winner_id;
        w_failed_nxt    = r_failed;
        w_elapsed_nxt   = r_elapsed;

        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt     = SEARCH;
                    w_key_valid_nxt = 1'b0;
                    w_key_out_nxt   = '0;
                    w_winner_nxt    = '0;
                    w_failed_nxt    = 1'b0;
                    w_elapsed_nxt   = '0;
                end
            end
            SEARCH: begin
                if (r_elapsed != '1) begin
                    w_elapsed_nxt = r_elapsed + TIMER_W'(1);
                end
                // A match outranks both exhaustion and an abort on the same cycle.
                if (w_any_found) begin
                    w_state_nxt     = FOUND;
                    w_key_out_nxt   = w_keys[w_win_idx];
                    w_winner_nxt    = w_win_idx;
                    w_key_valid_nxt = 1'b1;
                    w_stop_all_nxt  = 1'b1;
                end else if (&core_done) begin
                    w_state_nxt    = FAILED;
                    w_failed_nxt   = 1'b1;
                    w_stop_all_nxt = 1'b1;
                end else if (!start) begin
                    w_state_nxt    = IDLE;
                    w_stop_all_nxt = 1'b1;
                end
            end
            FOUND, FAILED: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_stop_all_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == SEARCH) begin
            w_display_nxt = w_key_or;
        end else if (w_key_valid_nxt) begin
            w_display_nxt = w_key_out_nxt;
        end else if (w_failed_nxt) begin
            w_display_nxt = '1;
        end else begin
            w_display_nxt = '0;
        end

        w_ledr_nxt                       = '0;
        w_ledr_nxt[9]                    = w_key_valid_nxt;
        w_ledr_nxt[8]                    = w_failed_nxt;
        w_ledr_nxt[7]                    = (w_state_nxt == SEARCH);
        w_ledr_nxt[CORE_COUNT_LOG_2-1:0] = w_winner_nxt;
    end

    // The edge detector resets to "start already high" so a level held
    // through reset never looks like a fresh request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q   <= 1'b1;
            r_stop_all  <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_out   <= '0;
            r_winner_id <= '0;
            r_failed    <= 1'b0;
            r_elapsed   <= '0;
            r_display   <= '0;
            r_ledr      <= '0;
        end else begin
            r_start_q   <= start;
            r_stop_all  <= w_stop_all_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_out   <= w_key_out_nxt;
            r_winner_id <= w_winner_nxt;
            r_failed    <= w_failed_nxt;
            r_elapsed   <= w_elapsed_nxt;
            r_display   <= w_display_nxt;
            r_ledr      <= w_ledr_nxt;
        end
    end

    assign stop_all       = r_stop_all;
    assign key_valid      = r_key_valid;
    assign key_out        = r_key_out;
    assign winner_id      = r_winner_id;
    assign search_failed  = r_failed;
    assign elapsed_cycles = r_elapsed;
    assign display        = r_display;
    assign ledr           = r_ledr;

endmodule
`default_nettype wire
